// File: rtl/rx_fifo_arbiter.sv
// rtl/rx_fifo_arbiter.sv - round-robin bounded-burst merge of receiver FIFOs into one tagged stream (option: RX_FIFO_ARBITER_WORD_CNT_EN)
module rx_fifo_arbiter #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                   BUS_CLK,
    input  logic                   BUS_RST_B,
    input  logic [CHANNELS-1:0]    CH_EN,
    input  logic [CHANNELS-1:0]    RX_FIFO_EMPTY,
    input  logic [24*CHANNELS-1:0] RX_FIFO_DATA,
    output logic [CHANNELS-1:0]    RX_FIFO_READ,
    input  logic                   FIFO_READ_NEXT,
    output logic                   FIFO_EMPTY,
    output logic [31:0]            FIFO_DATA,
    output logic [2:0]             GRANT,
    output logic [31:0]            WORD_CNT
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  last_q, last_d;
    logic [7:0]  burst_q, burst_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;

    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] rd_sel;
    logic                g_en;
    logic                g_empty;
    logic [23:0]         g_data;
    logic                load;
    logic                consume;
    logic                found;
    logic [2:0]          pick;
    int unsigned         cand;

    // Head-of-FIFO view of the granted channel.
    always_comb begin
        g_en    = 1'b0;
        g_empty = 1'b1;
        g_data  = '0;
        rd_sel  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_q == 3'(i)) begin
                g_en      = CH_EN[i];
                g_empty   = RX_FIFO_EMPTY[i];
                g_data    = RX_FIFO_DATA[24*i +: 24];
                rd_sel[i] = 1'b1;
            end
        end
    end

    assign consume      = valid_q & FIFO_READ_NEXT;
    assign load         = (state_q == ST_XFER) & g_en & ~g_empty & (~valid_q | FIFO_READ_NEXT);
    assign RX_FIFO_READ = load ? rd_sel : '0;
    assign req          = CH_EN & ~RX_FIFO_EMPTY;

    // Rotating search starting just after the last served channel.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            cand = 32'(last_q) + k;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (!found && (cand == i) && req[i]) begin
                    found = 1'b1;
                    pick  = 3'(i);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        valid_d = valid_q;
        data_d  = data_q;

        if (consume) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = {5'b0, grant_q, g_data};
            burst_d = burst_q + 8'd1;
        end

        case (state_q)
            ST_ARB: begin
                if (found) begin
                    grant_d = pick;
                    burst_d = 8'd0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // Empty only ends the burst when a load could otherwise have happened.
                if (!g_en
                    || (g_empty && (!valid_q || FIFO_READ_NEXT))
                    || (load && (burst_q + 8'd1 == 8'(MAX_BURST)))) begin
                    state_d = ST_ARB;
                    last_d  = grant_q;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B) begin
            state_q <= ST_ARB;
            grant_q <= 3'd0;
            last_q  <= 3'(CHANNELS - 1);
            burst_q <= 8'd0;
            valid_q <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign FIFO_EMPTY = ~valid_q;
    assign FIFO_DATA  = data_q;
    assign GRANT      = grant_q;

`ifdef RX_FIFO_ARBITER_WORD_CNT_EN
    logic [31:0] word_cnt_q;

    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B) begin
            word_cnt_q <= 32'd0;
        end else if (consume) begin
            word_cnt_q <= word_cnt_q + 32'd1;
        end
    end

    assign WORD_CNT = word_cnt_q;
`else
    assign WORD_CNT = 32'h0;
`endif

endmodule

// File: tb/tb_rx_fifo_arbiter.sv
// tb/tb_rx_fifo_arbiter.sv - directed self-checking bench for rx_fifo_arbiter with four modelled receiver FIFOs
module tb_rx_fifo_arbiter;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST_B;
    logic [3:0]  CH_EN;
    logic [3:0]  RX_FIFO_EMPTY;
    logic [95:0] RX_FIFO_DATA;
    logic [3:0]  RX_FIFO_READ;
    logic        FIFO_READ_NEXT;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [2:0]  GRANT;
    logic [31:0] WORD_CNT;

    always #5 BUS_CLK = ~BUS_CLK;

    rx_fifo_arbiter #(.CHANNELS(4), .MAX_BURST(16)) dut (
        .BUS_CLK        (BUS_CLK),
        .BUS_RST_B      (BUS_RST_B),
        .CH_EN          (CH_EN),
        .RX_FIFO_EMPTY  (RX_FIFO_EMPTY),
        .RX_FIFO_DATA   (RX_FIFO_DATA),
        .RX_FIFO_READ   (RX_FIFO_READ),
        .FIFO_READ_NEXT (FIFO_READ_NEXT),
        .FIFO_EMPTY     (FIFO_EMPTY),
        .FIFO_DATA      (FIFO_DATA),
        .GRANT          (GRANT),
        .WORD_CNT       (WORD_CNT)
    );

    // First-word-fall-through receiver FIFO models.
    logic [23:0] mem [4][128];
    logic [6:0]  wp [4] = '{default: '0};
    logic [6:0]  rp [4] = '{default: '0};
    logic [3:0]  pend = '0;

    for (genvar g = 0; g < 4; g++) begin : g_fifo
        assign RX_FIFO_EMPTY[g]          = (wp[g] == rp[g]);
        assign RX_FIFO_DATA[24*g +: 24]  = mem[g][rp[g]];
    end

    int cyc = 0;
    int pops [4] = '{default: 0};
    int viol_empty = 0;
    int viol_hold = 0;
    logic [31:0] out_q [$];
    int          out_cyc [$];

    always @(posedge BUS_CLK) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (pend[i]) rp[i] <= rp[i] + 7'd1;
        end
    end

    always @(negedge BUS_CLK) begin
        pend <= RX_FIFO_READ;
        for (int i = 0; i < 4; i++) begin
            if (RX_FIFO_READ[i]) begin
                pops[i] <= pops[i] + 1;
                if (RX_FIFO_EMPTY[i]) viol_empty <= viol_empty + 1;
            end
        end
        if ((|RX_FIFO_READ) && !FIFO_EMPTY && !FIFO_READ_NEXT) viol_hold <= viol_hold + 1;
        if (FIFO_READ_NEXT && !FIFO_EMPTY) begin
            out_q.push_back(FIFO_DATA);
            out_cyc.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_fail = 0;
    int b, b2, c0, p1, p2, vh, errs, gerrs, n_got, ec, k, exp_wc;
    int nxt [4];
    logic [31:0] got;

    task automatic tick(input int n);
        repeat (n) @(posedge BUS_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic [23:0] d);
        mem[ch][wp[ch]] = d;
        wp[ch] = wp[ch] + 7'd1;
    endtask

    task automatic do_reset();
        BUS_RST_B = 1'b0;
        tick(2);
        BUS_RST_B = 1'b1;
        tick(1);
    endtask

    task automatic wait_out(input string tag, input int target, input int budget);
        int n = 0;
        while (out_q.size() < target && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(out_q.size()), 32'(target));
    endtask

    task automatic chk_seq(input string tag, input int base, input int cnt, input logic [7:0] ch, input int first_n);
        int e = 0;
        for (int j = 0; j < cnt; j++) begin
            if (base + j >= out_q.size()) e++;
            else if (out_q[base+j] !== {ch, ch, 16'(first_n + j)}) e++;
        end
        chk(tag, 32'(e), 32'd0);
    endtask

    initial begin
        BUS_RST_B      = 1'b0;
        CH_EN          = 4'h0;
        FIFO_READ_NEXT = 1'b0;
        tick(2);
        chk("rst_fifo_empty", 32'(FIFO_EMPTY), 32'd1);
        chk("rst_fifo_data", FIFO_DATA, 32'd0);
        chk("rst_rx_read", 32'(RX_FIFO_READ), 32'd0);
        chk("rst_grant", 32'(GRANT), 32'd0);
        chk("rst_word_cnt", WORD_CNT, 32'd0);
        BUS_RST_B = 1'b1;
        tick(1);

        // Three words on channel 2 with downstream always ready.
        CH_EN = 4'hF;
        FIFO_READ_NEXT = 1'b1;
        b = out_q.size();
        p2 = pops[2];
        c0 = cyc;
        push(2, 24'h000001);
        push(2, 24'h000002);
        push(2, 24'h000003);
        tick(8);
        chk("t1_count", 32'(out_q.size() - b), 32'd3);
        chk("t1_w0", (out_q.size() > b) ? out_q[b] : 32'hDEADBEEF, 32'h02000001);
        chk("t1_w1", (out_q.size() > b + 1) ? out_q[b+1] : 32'hDEADBEEF, 32'h02000002);
        chk("t1_w2", (out_q.size() > b + 2) ? out_q[b+2] : 32'hDEADBEEF, 32'h02000003);
        chk("t1_latency", (out_q.size() > b) ? 32'(out_cyc[b] - c0) : 32'hFFFF, 32'd2);
        chk("t1_back_to_back", (out_q.size() > b + 2) ? 32'(out_cyc[b+2] - out_cyc[b]) : 32'hFFFF, 32'd2);
        chk("t1_pops", 32'(pops[2] - p2), 32'd3);
        chk("t1_empty_after", 32'(FIFO_EMPTY), 32'd1);
        chk("t1_grant", 32'(GRANT), 32'd2);

        // Fairness: 40 words on every channel, bursts of 16.
        do_reset();
        b = out_q.size();
        for (int ch = 0; ch < 4; ch++) begin
            for (int n = 0; n < 40; n++) push(ch, {8'(ch), 16'(n)});
        end
        wait_out("t2_all_delivered", b + 160, 400);
        errs = 0;
        gerrs = 0;
        nxt = '{default: 0};
        n_got = out_q.size() - b;
        for (int w = 0; w < n_got && w < 160; w++) begin
            if (w < 128) ec = (w % 64) / 16;
            else ec = (w - 128) / 8;
            got = out_q[b+w];
            if (got !== {8'(ec), 8'(ec), 16'(nxt[ec])}) errs++;
            nxt[ec]++;
            if (w > 0 && w < 128 && (out_cyc[b+w] - out_cyc[b+w-1]) != ((w % 16 == 0) ? 2 : 1)) gerrs++;
        end
        chk("t2_order", 32'(errs), 32'd0);
        chk("t2_switch_gaps", 32'(gerrs), 32'd0);
        chk("t2_inputs_drained", 32'(RX_FIFO_EMPTY), 32'hF);

        // Channel 1 streaming against a toggling downstream.
        b = out_q.size();
        p1 = pops[1];
        vh = viol_hold;
        for (int n = 0; n < 20; n++) push(1, {8'd1, 16'(100 + n)});
        for (int n = 0; n < 80; n++) begin
            FIFO_READ_NEXT = ~FIFO_READ_NEXT;
            tick(1);
        end
        FIFO_READ_NEXT = 1'b1;
        tick(4);
        chk("t3_count", 32'(out_q.size() - b), 32'd20);
        chk_seq("t3_order", b, 20, 8'd1, 100);
        chk("t3_no_pop_while_held", 32'(viol_hold - vh), 32'd0);
        chk("t3_pops", 32'(pops[1] - p1), 32'd20);

        // Disable channel 1 after five pops; grant moves on to channel 2.
        do_reset();
        b = out_q.size();
        p1 = pops[1];
        for (int n = 0; n < 20; n++) push(1, {8'd1, 16'(200 + n)});
        for (int n = 0; n < 10; n++) push(2, {8'd2, 16'(n)});
        k = 0;
        while (pops[1] - p1 < 5 && k < 50) begin
            tick(1);
            k++;
        end
        CH_EN = 4'b1101;
        tick(60);
        chk("t4_count", 32'(out_q.size() - b), 32'd15);
        chk_seq("t4_ch1_words", b, 5, 8'd1, 200);
        chk_seq("t4_ch2_words", b + 5, 10, 8'd2, 0);
        chk("t4_ch1_pops", 32'(pops[1] - p1), 32'd5);
        chk("t4_ch1_left", 32'(7'(wp[1] - rp[1])), 32'd15);
        chk("t4_grant", 32'(GRANT), 32'd2);
        CH_EN = 4'hF;
        wait_out("t4_reenable_count", b + 30, 100);
        chk_seq("t4_reenable_order", b + 15, 15, 8'd1, 205);

        // Reset pulse in the middle of a channel 2 burst.
        b = out_q.size();
        for (int n = 0; n < 20; n++) push(2, {8'd2, 16'(50 + n)});
        tick(5);
        for (int n = 0; n < 10; n++) begin
            push(0, {8'd0, 16'(n)});
            push(3, {8'd3, 16'(n)});
        end
        chk("t5_grant_mid", 32'(GRANT), 32'd2);
        chk("t5_busy_mid", 32'(FIFO_EMPTY), 32'd0);
        #1 BUS_RST_B = 1'b0;
        #1;
        chk("t5_rst_empty", 32'(FIFO_EMPTY), 32'd1);
        chk("t5_rst_read", 32'(RX_FIFO_READ), 32'd0);
        chk("t5_rst_data", FIFO_DATA, 32'd0);
        #1 BUS_RST_B = 1'b1;
        b2 = out_q.size();
        k = 0;
        while (out_q.size() <= b2 && k < 20) begin
            tick(1);
            k++;
        end
        chk("t5_restart_ch0", (out_q.size() > b2) ? 32'(out_q[b2][31:24]) : 32'hFF, 32'd0);
        k = 0;
        while (!(RX_FIFO_EMPTY == 4'hF && FIFO_EMPTY) && k < 300) begin
            tick(1);
            k++;
        end
        chk("t5_drained", 32'({RX_FIFO_EMPTY, FIFO_EMPTY}), 32'h1F);

        // Output word counter over 100 consumes.
        do_reset();
        b = out_q.size();
        for (int n = 0; n < 100; n++) push(0, {8'd0, 16'(n)});
        wait_out("t6_count", b + 100, 300);
        tick(2);
`ifdef RX_FIFO_ARBITER_WORD_CNT_EN
        exp_wc = 100;
`else
        exp_wc = 0;
`endif
        chk("t6_word_cnt", WORD_CNT, 32'(exp_wc));
        chk("no_pop_when_empty", 32'(viol_empty), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
